// File: rtl/ts_pkt_gen_mc.sv
// rtl/ts_pkt_gen_mc.sv - multi-channel MPEG-TS packet generator, round-robin over CH_NUM channels
// Optional macro TSGEN_PRBS_EN selects a PRBS-15 payload instead of the incrementing one.
module ts_pkt_gen_mc #(
   parameter int CH_NUM   = 4,
   parameter int CH_IDX_W = 2,
   parameter int GAP_DEF  = 4
) (
   input  logic                clk_100m,
   input  logic                rst_tsgen,
   input  logic [11:0]         lbus_addr,
   input  logic [15:0]         lbus_wdata,
   input  logic                lbus_we_n,
   input  logic                gen_en,
   input  logic                ts_ready,
   output logic                ts_valid,
   output logic                ts_sync,
   output logic                ts_eop,
   output logic [7:0]          ts_data,
   output logic [CH_IDX_W-1:0] ts_chn,
   output logic [31:0]         pkt_cnt
);
   typedef enum logic [2:0] {S_IDLE, S_SEL, S_HDR, S_PAY, S_GAP} state_t;

   state_t              state_q, state_d;
   logic [CH_NUM-1:0]   en_q;
   logic [1:0]          tsc_cfg_q [CH_NUM];
   logic [12:0]         pid_cfg_q [CH_NUM];
   logic [3:0]          cc_q      [CH_NUM];
   logic [CH_IDX_W-1:0] sel_q;
   logic [7:0]          gap_q;

   logic [CH_IDX_W-1:0] ptr_q, ptr_d, chn_q, chn_d;
   logic [7:0]          idx_q, idx_d, gap_cnt_q, gap_cnt_d;
   logic [12:0]         pid_q, pid_d;
   logic [1:0]          tsc_q, tsc_d;
   logic [3:0]          cc_lat_q, cc_lat_d;
   logic [31:0]         pkt_cnt_q;

   logic                wr, cc_clr, accept, last_acc, found;
   logic [CH_IDX_W-1:0] found_ch, cand;
   logic [7:0]          pay_byte;

   assign wr       = ~lbus_we_n;
   assign cc_clr   = wr && (lbus_addr == 12'h802);
   assign accept   = ts_valid & ts_ready;
   assign last_acc = accept && (state_q == S_PAY) && (idx_q == 8'd187);

   // Config registers; rst_tsgen release is already synchronous to clk_100m upstream.
   always_ff @(posedge clk_100m or posedge rst_tsgen) begin
      if (rst_tsgen) begin
         en_q  <= '0;
         sel_q <= '0;
         gap_q <= 8'(GAP_DEF);
         for (int i = 0; i < CH_NUM; i++) begin
            tsc_cfg_q[i] <= '0;
            pid_cfg_q[i] <= '0;
            cc_q[i]      <= '0;
         end
      end else begin
         if (wr) begin
            case (lbus_addr)
               12'h840: sel_q <= lbus_wdata[CH_IDX_W-1:0];
               12'h800: if (int'(sel_q) < CH_NUM) begin
                  en_q[sel_q]      <= lbus_wdata[15];
                  tsc_cfg_q[sel_q] <= lbus_wdata[14:13];
                  pid_cfg_q[sel_q] <= lbus_wdata[12:0];
               end
               12'h801: gap_q <= lbus_wdata[7:0];
               12'h802: for (int i = 0; i < CH_NUM; i++) cc_q[i] <= '0;
               default: ;
            endcase
         end
         // The finishing packet's increment lands on top of a same-cycle clear.
         if (last_acc) cc_q[chn_q] <= (cc_clr ? 4'd0 : cc_q[chn_q]) + 4'd1;
      end
   end

   always_comb begin
      found    = 1'b0;
      found_ch = '0;
      cand     = '0;
      for (int k = CH_NUM - 1; k >= 0; k--) begin
         cand = CH_IDX_W'((int'(ptr_q) + k) % CH_NUM);
         if (en_q[cand]) begin
            found    = 1'b1;
            found_ch = cand;
         end
      end
   end

   always_ff @(posedge clk_100m or posedge rst_tsgen) begin
      if (rst_tsgen) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         chn_q     <= '0;
         idx_q     <= '0;
         gap_cnt_q <= '0;
         pid_q     <= '0;
         tsc_q     <= '0;
         cc_lat_q  <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         chn_q     <= chn_d;
         idx_q     <= idx_d;
         gap_cnt_q <= gap_cnt_d;
         pid_q     <= pid_d;
         tsc_q     <= tsc_d;
         cc_lat_q  <= cc_lat_d;
         if (last_acc) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      chn_d     = chn_q;
      idx_d     = idx_q;
      gap_cnt_d = gap_cnt_q;
      pid_d     = pid_q;
      tsc_d     = tsc_q;
      cc_lat_d  = cc_lat_q;
      case (state_q)
         S_IDLE: if (gen_en) state_d = S_SEL;
         S_SEL: begin
            if (!gen_en || !found) begin
               state_d = S_IDLE;
            end else begin
               chn_d    = found_ch;
               pid_d    = pid_cfg_q[found_ch];
               tsc_d    = tsc_cfg_q[found_ch];
               cc_lat_d = cc_q[found_ch];
               ptr_d    = (found_ch == CH_IDX_W'(CH_NUM - 1)) ? '0 : found_ch + CH_IDX_W'(1);
               idx_d    = '0;
               state_d  = S_HDR;
            end
         end
         S_HDR: if (accept) begin
            idx_d = idx_q + 8'd1;
            if (idx_q == 8'd3) state_d = S_PAY;
         end
         S_PAY: if (accept) begin
            if (idx_q == 8'd187) begin
               idx_d = '0;
               if (gap_q == 8'd0) begin
                  state_d = S_SEL;
               end else begin
                  state_d   = S_GAP;
                  gap_cnt_d = gap_q;
               end
            end else begin
               idx_d = idx_q + 8'd1;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - 8'd1;
            if (gap_cnt_q == 8'd1) state_d = S_SEL;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef TSGEN_PRBS_EN
   logic [14:0] lfsr_q;

   function automatic logic [14:0] lfsr_step8(input logic [14:0] s);
      logic [14:0] r;
      r = s;
      for (int i = 0; i < 8; i++) r = {r[13:0], r[14] ^ r[13]};
      return r;
   endfunction

   always_ff @(posedge clk_100m or posedge rst_tsgen) begin
      if (rst_tsgen)                         lfsr_q <= 15'h4A80;
      else if (state_q == S_SEL)             lfsr_q <= 15'h4A80;
      else if (accept && state_q == S_PAY)   lfsr_q <= lfsr_step8(lfsr_q);
   end

   assign pay_byte = lfsr_q[14:7];
`else
   assign pay_byte = idx_q - 8'd4;
`endif

   always_comb begin
      ts_valid = (state_q == S_HDR) || (state_q == S_PAY);
      ts_sync  = (state_q == S_HDR) && (idx_q == 8'd0);
      ts_eop   = (state_q == S_PAY) && (idx_q == 8'd187);
      ts_data  = 8'h00;
      if (state_q == S_HDR) begin
         case (idx_q[1:0])
            2'd0: ts_data = 8'h47;
            2'd1: ts_data = {3'b010, pid_q[12:8]};
            2'd2: ts_data = pid_q[7:0];
            2'd3: ts_data = {tsc_q, 2'b01, cc_lat_q};
         endcase
      end else if (state_q == S_PAY) begin
         ts_data = pay_byte;
      end
   end

   assign ts_chn  = chn_q;
   assign pkt_cnt = pkt_cnt_q;
endmodule
